// File: rtl/dma_priority_resolver_pkg.sv
// Shared types and constants for the DMA request priority resolver.
package DMA_Pkg;

    localparam int NUM_CHANNELS = 4;

    typedef logic [1:0] chan_id_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_OFFER   = 2'd1,
        ST_SERVICE = 2'd2
    } res_state_t;

    // Last = 3 makes channel 0 the first one looked at after reset.
    localparam chan_id_t LAST_RESET = 2'd3;

endpackage

// File: rtl/dma_rotate_pri_enc.sv
// Priority encoder over the effective request vector. Search order is
// Last+1, Last+2, Last+3, Last (mod 4); fixed priority is the same search
// anchored at Last = 3, which yields 0,1,2,3.
import DMA_Pkg::*;

module dma_rotate_pri_enc (
    input  logic [NUM_CHANNELS-1:0] i_eff,
    input  chan_id_t                i_last,
    input  logic                    i_rotating,
    output chan_id_t                o_winner,
    output logic                    o_any
);

    chan_id_t w_base;
    chan_id_t w_idx;

    assign w_base = i_rotating ? i_last : LAST_RESET;

    // Scan from lowest to highest priority so the highest-priority hit is written last.
    always_comb begin
        o_winner = '0;
        o_any    = 1'b0;
        w_idx    = '0;
        for (int i = NUM_CHANNELS; i >= 1; i--) begin
            w_idx = w_base + chan_id_t'(i);
            if (i_eff[w_idx]) begin
                o_winner = w_idx;
                o_any    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dma_priority_resolver.sv
// DMA request priority resolver: synchronizes device requests, merges
// masks and software requests, and offers one channel at a time to the
// timing control through an IDLE/OFFER/SERVICE handshake.
import DMA_Pkg::*;

module dma_priority_resolver (
    input  logic                    CLK,
    input  logic                    RESET_N,
    input  logic [NUM_CHANNELS-1:0] DREQ,
    input  logic                    DREQSense,
    input  logic                    RotatingPri,
    input  logic                    ControllerDisable,
    input  logic [NUM_CHANNELS-1:0] MaskBits,
    input  logic [NUM_CHANNELS-1:0] SwReq,
    input  logic                    MasterClear,
    input  logic                    Ack,
    input  logic                    ServiceDone,
    output logic                    ValidReqID,
    output logic [1:0]              ReqID,
    output logic [NUM_CHANNELS-1:0] ReqStatus
);

    logic [NUM_CHANNELS-1:0] w_norm;
    logic [NUM_CHANNELS-1:0] w_eff;
    logic [NUM_CHANNELS-1:0] r_sync1;
    logic [NUM_CHANNELS-1:0] r_sync2;
    res_state_t              r_state;
    res_state_t              w_next_state;
    chan_id_t                r_req_id;
    chan_id_t                r_last;
    chan_id_t                w_winner;
    logic                    w_any;
    logic                    w_grant;

    // Normalise polarity before synchronizing so the sync flops reset to "inactive".
    assign w_norm    = DREQ ^ {NUM_CHANNELS{DREQSense}};
    // Software requests bypass the mask.
    assign w_eff     = (r_sync2 & ~MaskBits) | SwReq;
    assign ReqStatus = r_sync2 | SwReq;
    assign ReqID     = r_req_id;
    assign w_grant   = (r_state == ST_IDLE) && !ControllerDisable && w_any;

    dma_rotate_pri_enc u_pri_enc (
        .i_eff      (w_eff),
        .i_last     (r_last),
        .i_rotating (RotatingPri),
        .o_winner   (w_winner),
        .o_any      (w_any)
    );

    // Two-flop synchronizer per channel for the asynchronous DREQ pins.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else if (MasterClear) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= w_norm;
            r_sync2 <= r_sync1;
        end
    end

    // Resolver state register.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state <= ST_IDLE;
        end else if (MasterClear) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; Ack wins over a request withdrawn in the same cycle.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_grant) begin
                    w_next_state = ST_OFFER;
                end
            end
            ST_OFFER: begin
                if (Ack) begin
                    w_next_state = ST_SERVICE;
                end else if (!w_eff[r_req_id]) begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_SERVICE: begin
                if (ServiceDone) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Offer is visible to timing control only while in OFFER.
    always_comb begin
        ValidReqID = (r_state == ST_OFFER);
    end

    // Capture the winner only when leaving IDLE; it is frozen through OFFER and SERVICE.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_req_id <= '0;
        end else if (MasterClear) begin
            r_req_id <= '0;
        end else if (w_grant) begin
            r_req_id <= w_winner;
        end
    end

    // Rotation pointer advances to the serviced channel at end of service.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_last <= LAST_RESET;
        end else if (MasterClear) begin
            r_last <= LAST_RESET;
        end else if ((r_state == ST_SERVICE) && ServiceDone && RotatingPri) begin
            r_last <= r_req_id;
        end
    end

endmodule

// File: tb/tb_dma_priority_resolver.sv
// Self-checking bench for dma_priority_resolver.
module tb_dma_priority_resolver;

    logic       CLK;
    logic       RESET_N;
    logic [3:0] DREQ;
    logic       DREQSense;
    logic       RotatingPri;
    logic       ControllerDisable;
    logic [3:0] MaskBits;
    logic [3:0] SwReq;
    logic       MasterClear;
    logic       Ack;
    logic       ServiceDone;
    logic       ValidReqID;
    logic [1:0] ReqID;
    logic [3:0] ReqStatus;

    int total = 0;
    int bad   = 0;
    int exp_q[$];
    int exp_id;

    dma_priority_resolver dut (
        .CLK               (CLK),
        .RESET_N           (RESET_N),
        .DREQ              (DREQ),
        .DREQSense         (DREQSense),
        .RotatingPri       (RotatingPri),
        .ControllerDisable (ControllerDisable),
        .MaskBits          (MaskBits),
        .SwReq             (SwReq),
        .MasterClear       (MasterClear),
        .Ack               (Ack),
        .ServiceDone       (ServiceDone),
        .ValidReqID        (ValidReqID),
        .ReqID             (ReqID),
        .ReqStatus         (ReqStatus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic pop_exp();
        if (exp_q.size() == 0) begin
            total++; bad++;
            $display("FAIL scoreboard_empty: got no expected entry, required one");
            exp_id = -1;
        end else begin
            exp_id = exp_q.pop_front();
        end
    endtask

    task automatic test_reset();
        RESET_N = 1'b0; DREQ = 4'h0; DREQSense = 1'b0; RotatingPri = 1'b0;
        ControllerDisable = 1'b0; MaskBits = 4'h0; SwReq = 4'h0;
        MasterClear = 1'b0; Ack = 1'b0; ServiceDone = 1'b0;
        #3;
        total++; if (ValidReqID !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b required 0", ValidReqID); end
        total++; if (ReqID !== 2'd0) begin bad++; $display("FAIL reset_reqid: got %0d required 0", ReqID); end
        total++; if (ReqStatus !== 4'h0) begin bad++; $display("FAIL reset_status: got %b required 0000", ReqStatus); end
        tick(); tick();
        RESET_N = 1'b1;
        tick();
    endtask

    task automatic test_fixed_latency();
        DREQ = 4'b0110;
        exp_q.push_back(1);
        tick(); tick();
        total++; if (ValidReqID !== 1'b0) begin bad++; $display("FAIL fixed_early: got %b required 0 after 2 edges", ValidReqID); end
        tick();
        total++; if (ValidReqID !== 1'b1) begin bad++; $display("FAIL fixed_valid: got %b required 1 on 3rd edge", ValidReqID); end
        pop_exp();
        total++; if (ReqID !== exp_id[1:0]) begin bad++; $display("FAIL fixed_reqid: got %0d required %0d", ReqID, exp_id); end
        total++; if (ReqStatus !== 4'b0110) begin bad++; $display("FAIL fixed_status: got %b required 0110", ReqStatus); end
        Ack = 1'b1; tick(); Ack = 1'b0;
        total++; if (ValidReqID !== 1'b0) begin bad++; $display("FAIL fixed_ack: got %b required 0", ValidReqID); end
        total++; if (ReqID !== 2'd1) begin bad++; $display("FAIL fixed_hold: got %0d required 1", ReqID); end
        DREQ = 4'h0; tick(); tick();
        ServiceDone = 1'b1; tick(); ServiceDone = 1'b0;
        tick(); tick();
        total++; if (ValidReqID !== 1'b0) begin bad++; $display("FAIL fixed_idle: got %b required 0", ValidReqID); end
    endtask

    task automatic test_rotating();
        int n;
        RotatingPri = 1'b1;
        DREQ = 4'b1111;
        exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(2);
        exp_q.push_back(3); exp_q.push_back(0);
        for (int k = 0; k < 5; k++) begin
            n = 0;
            while (!ValidReqID && n < 12) begin tick(); n++; end
            total++; if (ValidReqID !== 1'b1) begin bad++; $display("FAIL rot_timeout_%0d: got valid %b required 1", k, ValidReqID); end
            pop_exp();
            total++; if (ReqID !== exp_id[1:0]) begin bad++; $display("FAIL rot_order_%0d: got %0d required %0d", k, ReqID, exp_id); end
            Ack = 1'b1; tick(); Ack = 1'b0;
            total++; if (ValidReqID !== 1'b0) begin bad++; $display("FAIL rot_ack_%0d: got %b required 0", k, ValidReqID); end
            if (k == 4) begin DREQ = 4'h0; tick(); tick(); end
            ServiceDone = 1'b1; tick(); ServiceDone = 1'b0;
        end
        tick(); tick();
        total++; if (ValidReqID !== 1'b0) begin bad++; $display("FAIL rot_idle: got %b required 0", ValidReqID); end
        RotatingPri = 1'b0;
    endtask

    task automatic test_sense_mask_swreq();
        DREQSense = 1'b1; DREQ = 4'b1110; MaskBits = 4'b0001;
        tick(); tick(); tick(); tick();
        total++; if (ValidReqID !== 1'b0) begin bad++; $display("FAIL mask_nogrant: got %b required 0", ValidReqID); end
        total++; if (ReqStatus !== 4'b0001) begin bad++; $display("FAIL mask_status: got %b required 0001", ReqStatus); end
        SwReq = 4'b0001;
        exp_q.push_back(0);
        tick();
        total++; if (ValidReqID !== 1'b1) begin bad++; $display("FAIL swreq_valid: got %b required 1 after 1 edge", ValidReqID); end
        pop_exp();
        total++; if (ReqID !== exp_id[1:0]) begin bad++; $display("FAIL swreq_reqid: got %0d required %0d", ReqID, exp_id); end
        Ack = 1'b1; tick(); Ack = 1'b0;
        SwReq = 4'h0;
        ServiceDone = 1'b1; tick(); ServiceDone = 1'b0;
        tick();
        total++; if (ValidReqID !== 1'b0) begin bad++; $display("FAIL swreq_idle: got %b required 0", ValidReqID); end
        DREQSense = 1'b0; DREQ = 4'h0;
        tick(); tick(); tick();
        MaskBits = 4'h0;
        tick();
    endtask

    task automatic test_disable();
        ControllerDisable = 1'b1; SwReq = 4'b0010;
        tick(); tick(); tick();
        total++; if (ValidReqID !== 1'b0) begin bad++; $display("FAIL disable_block: got %b required 0", ValidReqID); end
        ControllerDisable = 1'b0;
        exp_q.push_back(1);
        tick();
        total++; if (ValidReqID !== 1'b1) begin bad++; $display("FAIL disable_release: got %b required 1", ValidReqID); end
        pop_exp();
        total++; if (ReqID !== exp_id[1:0]) begin bad++; $display("FAIL disable_reqid: got %0d required %0d", ReqID, exp_id); end
        Ack = 1'b1; tick(); Ack = 1'b0;
        SwReq = 4'h0;
        ServiceDone = 1'b1; tick(); ServiceDone = 1'b0;
        tick();
    endtask

    task automatic test_withdraw();
        DREQ = 4'b0100;
        exp_q.push_back(2);
        tick(); tick(); tick();
        total++; if (ValidReqID !== 1'b1) begin bad++; $display("FAIL wd_offer: got %b required 1", ValidReqID); end
        pop_exp();
        total++; if (ReqID !== exp_id[1:0]) begin bad++; $display("FAIL wd_reqid: got %0d required %0d", ReqID, exp_id); end
        DREQ = 4'h0;
        tick(); tick();
        total++; if (ValidReqID !== 1'b1) begin bad++; $display("FAIL wd_early: got %b required 1 after 2 edges", ValidReqID); end
        tick();
        total++; if (ValidReqID !== 1'b0) begin bad++; $display("FAIL wd_drop: got %b required 0 after 3 edges", ValidReqID); end
        // Withdrawal coinciding with Ack must still enter SERVICE.
        DREQ = 4'b0100;
        tick(); tick(); tick();
        total++; if (ValidReqID !== 1'b1 || ReqID !== 2'd2) begin bad++; $display("FAIL wd2_offer: got valid %b id %0d required 1 id 2", ValidReqID, ReqID); end
        DREQ = 4'h0;
        tick(); tick();
        Ack = 1'b1; tick(); Ack = 1'b0;
        SwReq = 4'b0001;
        tick();
        total++; if (ValidReqID !== 1'b0) begin bad++; $display("FAIL wd2_service: got %b required 0 (held in SERVICE)", ValidReqID); end
        exp_q.push_back(0);
        ServiceDone = 1'b1; tick(); ServiceDone = 1'b0;
        tick();
        total++; if (ValidReqID !== 1'b1) begin bad++; $display("FAIL wd2_regrant: got %b required 1", ValidReqID); end
        pop_exp();
        total++; if (ReqID !== exp_id[1:0]) begin bad++; $display("FAIL wd2_reqid: got %0d required %0d", ReqID, exp_id); end
        Ack = 1'b1; tick(); Ack = 1'b0;
        SwReq = 4'h0;
        ServiceDone = 1'b1; tick(); ServiceDone = 1'b0;
        tick();
    endtask

    task automatic test_reset_in_service();
        RotatingPri = 1'b1;
        DREQ = 4'b1111;
        exp_q.push_back(1);
        tick(); tick(); tick();
        pop_exp();
        total++; if (ValidReqID !== 1'b1 || ReqID !== exp_id[1:0]) begin bad++; $display("FAIL rst_pre: got valid %b id %0d required 1 id %0d", ValidReqID, ReqID, exp_id); end
        Ack = 1'b1; tick(); Ack = 1'b0;
        #2 RESET_N = 1'b0;
        #1;
        total++; if (ValidReqID !== 1'b0) begin bad++; $display("FAIL rst_async_valid: got %b required 0", ValidReqID); end
        total++; if (ReqID !== 2'd0) begin bad++; $display("FAIL rst_async_reqid: got %0d required 0", ReqID); end
        @(posedge CLK); #1;
        RESET_N = 1'b1;
        exp_q.push_back(0);
        tick(); tick();
        total++; if (ValidReqID !== 1'b0) begin bad++; $display("FAIL rst_resync: got %b required 0", ValidReqID); end
        tick();
        total++; if (ValidReqID !== 1'b1) begin bad++; $display("FAIL rst_regrant: got %b required 1", ValidReqID); end
        pop_exp();
        total++; if (ReqID !== exp_id[1:0]) begin bad++; $display("FAIL rst_first: got %0d required %0d", ReqID, exp_id); end
        Ack = 1'b1; tick(); Ack = 1'b0;
        exp_q.push_back(1);
        ServiceDone = 1'b1; tick(); ServiceDone = 1'b0;
        tick();
        pop_exp();
        total++; if (ValidReqID !== 1'b1 || ReqID !== exp_id[1:0]) begin bad++; $display("FAIL rst_second: got valid %b id %0d required 1 id %0d", ValidReqID, ReqID, exp_id); end
        DREQ = 4'h0;
        Ack = 1'b1; tick(); Ack = 1'b0;
        tick(); tick();
        ServiceDone = 1'b1; tick(); ServiceDone = 1'b0;
        RotatingPri = 1'b0;
        tick();
    endtask

    task automatic test_master_clear();
        SwReq = 4'b0010;
        tick();
        total++; if (ValidReqID !== 1'b1 || ReqID !== 2'd1) begin bad++; $display("FAIL mc_pre: got valid %b id %0d required 1 id 1", ValidReqID, ReqID); end
        MasterClear = 1'b1; Ack = 1'b1;
        tick();
        MasterClear = 1'b0; Ack = 1'b0; SwReq = 4'h0;
        total++; if (ValidReqID !== 1'b0) begin bad++; $display("FAIL mc_valid: got %b required 0", ValidReqID); end
        total++; if (ReqID !== 2'd0) begin bad++; $display("FAIL mc_reqid: got %0d required 0", ReqID); end
        tick(); tick();
        total++; if (ValidReqID !== 1'b0) begin bad++; $display("FAIL mc_idle: got %b required 0", ValidReqID); end
    endtask

    initial begin
        test_reset();
        test_fixed_latency();
        test_rotating();
        test_sense_mask_swreq();
        test_disable();
        test_withdraw();
        test_reset_in_service();
        test_master_clear();
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL scoreboard_left: got %0d entries required 0", exp_q.size()); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
